wb_pipe: RTL
============

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter DATA_W, default 16, width of every data path and Write_Data.
REQ-002 Parameter REG_W, default 3, width of destination-register index.
REQ-003 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  upstream (memory stage) holds a valid instruction.
REQ-007 in_ready  out  1  block accepts the upstream instruction this cycle.
REQ-008 RegSrcSel  in  2  write-data source: 00 PC, 01 Read_Data, 10 Addr, 11 Imm_Ext.
REQ-009 PC, Read_Data, Addr, Imm_Ext  in  DATA_W each  candidate write-data sources.
REQ-010 in_wr_en  in  1  instruction writes the register file.
REQ-011 in_wr_reg  in  REG_W  destination register index.
REQ-012 in_halt  in  1  instruction is HALT.
REQ-013 flush  in  1  discard all held, not yet retired entries.
REQ-014 out_valid  out  1  Write_Data/Write_Reg/Write_En describe a retiring instruction.
REQ-015 out_ready  in  1  register-file write port accepts the retiring instruction.
REQ-016 Write_Data  out  DATA_W; Write_Reg  out  REG_W; Write_En  out  1 (out_valid AND held wr_en).
REQ-017 halted  out  1  sticky: a HALT has retired.
REQ-018 retired  out  CNT_W  count of retired instructions.

Function
REQ-019 Source selection SHALL occur on input side; selected value SHALL be registered, not re-muxed at output.
REQ-020 Storage SHALL be a 2-entry skid buffer (main + skid); in_ready SHALL be registered and equal "skid empty AND NOT halted AND NOT halt held".
REQ-021 Transfer in SHALL occur on in_valid AND in_ready; transfer out on out_valid AND out_ready.
REQ-022 Latency: accepted instruction SHALL appear on out_valid the next cycle when buffer empty; full throughput (1/cycle) while out_ready=1.
REQ-023 States: EMPTY (out_valid=0), ONE (main full), TWO (main+skid full, in_ready=0).
REQ-024 EMPTY->ONE on accept; ONE->ONE on accept+retire; ONE->EMPTY on retire without accept; ONE->TWO on accept without retire; TWO->ONE on retire (skid moves to main, order preserved).
REQ-025 Accept in TWO SHALL be impossible; data in skid SHALL never be overwritten.
REQ-026 flush SHALL empty both entries next cycle, suppress any same-cycle accept, but SHALL NOT suppress a same-cycle retire (retire wins over flush for main entry).
REQ-027 On retire of an entry with halt=1, halted SHALL set next cycle and remain 1 until reset; any younger held entry SHALL be discarded.
REQ-028 Once a HALT is accepted, in_ready SHALL be 0 until reset.
REQ-029 retired SHALL increment by 1 per retire, saturating at all-ones (no wrap).
REQ-030 Write_En SHALL be 0 whenever out_valid=0; outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-031 Selection SHALL be fully decoded; no X on Write_Data for any RegSrcSel.

Reset
REQ-032 rst_n=0 at a clock edge SHALL clear both entries, out_valid=0, Write_En=0, Write_Data=0, Write_Reg=0, halted=0, retired=0, in_ready=0 during reset and 1 the cycle after release.
REQ-033 Reset mid-operation SHALL discard held entries with no retire reported.

Verification
REQ-034 Sel sweep: DATA_W=16, PC=0x1111, Read_Data=0x2222, Addr=0x3333, Imm_Ext=0xFFF4, RegSrcSel 00..11, out_ready=1 -> Write_Data 0x1111,0x2222,0x3333,0xFFF4 one cycle after each accept.
REQ-035 Backpressure: 3 back-to-back instructions, out_ready=0 -> in_ready drops after 2 accepted; raise out_ready -> retire in order, third accepted, no loss/duplication.
REQ-036 Flush: TWO state, flush=1, out_ready=1 same cycle -> main retires (retired+1), skid discarded, out_valid=0 next cycle.
REQ-037 Halt: accept HALT then another valid -> second not accepted; HALT retires -> halted=1, in_ready stays 0.
REQ-038 Saturation: CNT_W=4, 20 retires -> retired=0xF.
REQ-039 Reset: rst_n=0 while TWO -> next cycle out_valid=0, retired=0, halted=0.

Source files
------------

// File: rtl/wb_pipe.sv
// Write-back stage: selects the register-file write data on the input side
// and holds it in a two-entry skid buffer ahead of the register-file write port.
module wb_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        RegSrcSel,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Read_Data,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] Imm_Ext,
  input  logic              in_wr_en,
  input  logic [REG_W-1:0]  in_wr_reg,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Write_Data,
  output logic [REG_W-1:0]  Write_Reg,
  output logic              Write_En,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  state_t              state_r, state_nxt_s;

  logic [DATA_W-1:0]   main_data_r, main_data_nxt_s;
  logic [REG_W-1:0]    main_reg_r,  main_reg_nxt_s;
  logic                main_wen_r,  main_wen_nxt_s;
  logic                main_halt_r, main_halt_nxt_s;

  logic [DATA_W-1:0]   skid_data_r, skid_data_nxt_s;
  logic [REG_W-1:0]    skid_reg_r,  skid_reg_nxt_s;
  logic                skid_wen_r,  skid_wen_nxt_s;
  logic                skid_halt_r, skid_halt_nxt_s;

  logic                in_ready_r, in_ready_nxt_s;
  logic                out_valid_r, write_en_r;
  logic                halted_r, halted_nxt_s;
  logic                halt_seen_r, halt_seen_nxt_s;
  logic [CNT_W-1:0]    retired_r, retired_nxt_s;

  logic [DATA_W-1:0]   sel_data_s;
  logic                accept_s, retire_s, retire_halt_s;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign Write_Data = main_data_r;
  assign Write_Reg  = main_reg_r;
  assign Write_En   = write_en_r;
  assign halted     = halted_r;
  assign retired    = retired_r;

  // Input-side write-data source select
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    case (RegSrcSel)
      2'b00:   sel_data_s = PC;
      2'b01:   sel_data_s = Read_Data;
      2'b10:   sel_data_s = Addr;
      2'b11:   sel_data_s = Imm_Ext;
      default: sel_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Flush blocks any same-cycle accept; a retire still goes through.
  assign accept_s      = in_valid & in_ready_r & ~flush;
  assign retire_s      = out_valid_r & out_ready;
  assign retire_halt_s = retire_s & main_halt_r;

  // Buffer occupancy, entry movement, sticky flags and counter
  always_comb begin
    state_nxt_s     = state_r;
    main_data_nxt_s = main_data_r;
    main_reg_nxt_s  = main_reg_r;
    main_wen_nxt_s  = main_wen_r;
    main_halt_nxt_s = main_halt_r;
    skid_data_nxt_s = skid_data_r;
    skid_reg_nxt_s  = skid_reg_r;
    skid_wen_nxt_s  = skid_wen_r;
    skid_halt_nxt_s = skid_halt_r;

    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          main_data_nxt_s = sel_data_s;
          main_reg_nxt_s  = in_wr_reg;
          main_wen_nxt_s  = in_wr_en;
          main_halt_nxt_s = in_halt;
          state_nxt_s     = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (flush || retire_halt_s) begin
          state_nxt_s = ST_EMPTY;
        end else if (retire_s && accept_s) begin
          main_data_nxt_s = sel_data_s;
          main_reg_nxt_s  = in_wr_reg;
          main_wen_nxt_s  = in_wr_en;
          main_halt_nxt_s = in_halt;
          state_nxt_s     = ST_ONE;
        end else if (retire_s) begin
          state_nxt_s = ST_EMPTY;
        end else if (accept_s) begin
          skid_data_nxt_s = sel_data_s;
          skid_reg_nxt_s  = in_wr_reg;
          skid_wen_nxt_s  = in_wr_en;
          skid_halt_nxt_s = in_halt;
          state_nxt_s     = ST_TWO;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        // A retiring HALT drops the younger skid entry.
        if (flush || retire_halt_s) begin
          state_nxt_s = ST_EMPTY;
        end else if (retire_s) begin
          main_data_nxt_s = skid_data_r;
          main_reg_nxt_s  = skid_reg_r;
          main_wen_nxt_s  = skid_wen_r;
          main_halt_nxt_s = skid_halt_r;
          state_nxt_s     = ST_ONE;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase

    halted_nxt_s    = halted_r | retire_halt_s;
    halt_seen_nxt_s = halt_seen_r | (accept_s & in_halt);
    in_ready_nxt_s  = (state_nxt_s != ST_TWO) & ~halted_nxt_s & ~halt_seen_nxt_s;

    if (retire_s && !(&retired_r)) begin
      retired_nxt_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_nxt_s = retired_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_data_r <= {DATA_W{1'b0}};
      main_reg_r  <= {REG_W{1'b0}};
      main_wen_r  <= 1'b0;
      main_halt_r <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_reg_r  <= {REG_W{1'b0}};
      skid_wen_r  <= 1'b0;
      skid_halt_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      write_en_r  <= 1'b0;
      halted_r    <= 1'b0;
      halt_seen_r <= 1'b0;
      retired_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      main_data_r <= main_data_nxt_s;
      main_reg_r  <= main_reg_nxt_s;
      main_wen_r  <= main_wen_nxt_s;
      main_halt_r <= main_halt_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_reg_r  <= skid_reg_nxt_s;
      skid_wen_r  <= skid_wen_nxt_s;
      skid_halt_r <= skid_halt_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      write_en_r  <= (state_nxt_s != ST_EMPTY) & main_wen_nxt_s;
      halted_r    <= halted_nxt_s;
      halt_seen_r <= halt_seen_nxt_s;
      retired_r   <= retired_nxt_s;
    end
  end

endmodule
